// File: rtl/shift_cmd_pkg.sv
// Shared types for the shift-register command sequencer: mode encodings,
// FSM state type, the 9-bit {mode, data, count} command record and a helper
// that turns a 3-bit count field into a cycle count.
package shift_cmd_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned COUNT_W = 3;
  localparam int unsigned CMD_W   = MODE_W + DATA_W + COUNT_W;
  localparam int unsigned REM_W   = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    mode_e              mode;
    logic [DATA_W-1:0]  data;
    logic [COUNT_W-1:0] count;
  } cmd_t;

  // A zero count field stands for the maximum window of 8 cycles.
  function automatic logic [REM_W-1:0] cmd_cycles(input logic [COUNT_W-1:0] count);
    return (count == '0) ? REM_W'(8) : REM_W'(count);
  endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous FIFO for buffered commands.
// Ports: clock, reset (async, active-high), push/wdata write side,
// pop/rdata read side (rdata shows the head entry combinationally),
// full, empty, occupancy (0..DEPTH).
// A push while full is dropped; a pop while empty is ignored.
module shift_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (occupancy == OW'(DEPTH));
  assign empty     = (occupancy == '0);
  assign do_push_c = push && !full;
  assign do_pop_c  = pop && !empty;
  assign rdata     = mem[rd_ptr];

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer for a downstream universal shift register.
// Commands {mode, data, count} are buffered in a FIFO and replayed onto
// MODE/DATAIN for count cycles each (count 0 = 8 cycles), back to back.
// Ports: clock, reset (async, active-high); cmd_valid/cmd_ready handshake
// with cmd_mode/cmd_data/cmd_count; registered MODE, DATAIN, cmd_done
// (pulse on the last cycle of a command); busy and cmd_ready derive from
// registered state only.
module shift_cmd_sequencer
  import shift_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [MODE_W-1:0]  cmd_mode,
  input  logic [DATA_W-1:0]  cmd_data,
  input  logic [COUNT_W-1:0] cmd_count,
  output logic [MODE_W-1:0]  MODE,
  output logic [DATA_W-1:0]  DATAIN,
  output logic               busy,
  output logic               cmd_done
);

  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

  state_e           state;
  logic [REM_W-1:0] remaining;
  logic             ready_en;
  cmd_t             push_cmd;
  cmd_t             head_cmd;
  logic [CMD_W-1:0] head_raw;
  logic [REM_W-1:0] head_cycles_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OCC_W-1:0] fifo_occ;
  logic             push_c;
  logic             pop_c;

  // ready_en holds cmd_ready low until the first edge after reset releases.
  assign cmd_ready     = ready_en && !fifo_full;
  assign busy          = (state == ISSUE) || (fifo_occ != '0);
  assign push_c        = cmd_valid && cmd_ready;
  assign push_cmd      = '{mode: mode_e'(cmd_mode), data: cmd_data, count: cmd_count};
  assign head_cmd      = cmd_t'(head_raw);
  assign head_cycles_c = cmd_cycles(head_cmd.count);

  // Pop when idle, or on the last cycle of a window so the next command follows with no gap.
  assign pop_c = !fifo_empty &&
                 ((state == IDLE) || ((state == ISSUE) && (remaining == REM_W'(1))));

  shift_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .wdata     (push_cmd),
    .pop       (pop_c),
    .rdata     (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  // Issue FSM with registered MODE/DATAIN/cmd_done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      ready_en  <= 1'b0;
      MODE      <= MODE_HOLD;
      DATAIN    <= '0;
      cmd_done  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      cmd_done <= 1'b0;

      unique case (state)
        IDLE:    if (pop_c) state <= ISSUE;
        ISSUE:   if ((remaining == REM_W'(1)) && !pop_c) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (pop_c) begin
        MODE      <= head_cmd.mode;
        DATAIN    <= head_cmd.data;
        remaining <= head_cycles_c;
        cmd_done  <= (head_cycles_c == REM_W'(1));
      end else if ((state == ISSUE) && (remaining != REM_W'(1))) begin
        remaining <= remaining - REM_W'(1);
        // Flag the final cycle one edge ahead so cmd_done stays registered.
        cmd_done  <= (remaining == REM_W'(2));
      end else begin
        MODE      <= MODE_HOLD;
        DATAIN    <= '0;
        remaining <= '0;
      end
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Self-checking bench for shift_cmd_sequencer. Accepted commands expand into
// per-cycle expectations {MODE, DATAIN, cmd_done} queued at the accepting edge;
// a monitor pops one per issue cycle and flags extra, missing or gapped cycles.
module tb_shift_cmd_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'b00;
  logic [3:0] cmd_data = 4'b0000;
  logic [2:0] cmd_count = 3'b000;
  logic [1:0] MODE;
  logic [3:0] DATAIN;
  logic       busy;
  logic       cmd_done;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] data;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   started = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  shift_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .MODE      (MODE),
    .DATAIN    (DATAIN),
    .busy      (busy),
    .cmd_done  (cmd_done)
  );

  // Issue monitor: every non-hold cycle (and every cycle while a run is open) consumes one expectation.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      started = 1'b0;
    end else if (started || MODE !== 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_extra MODE=%b DATAIN=%b done=%b required idle", MODE, DATAIN, cmd_done);
        started = 1'b0;
      end else begin
        mon_e = exp_q.pop_front();
        if (MODE !== mon_e.mode || DATAIN !== mon_e.data || cmd_done !== mon_e.done) begin
          errors++;
          $display("FAIL issue_seq got MODE=%b DATAIN=%b done=%b required MODE=%b DATAIN=%b done=%b",
                   MODE, DATAIN, cmd_done, mon_e.mode, mon_e.data, mon_e.done);
        end
        started = (exp_q.size() != 0);
      end
    end else begin
      checks++;
      if (DATAIN !== 4'b0000 || cmd_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs DATAIN=%b done=%b required 0000/0", DATAIN, cmd_done);
      end
    end
  end

  // Drive a command from a negedge, hold until accepted, queue its expected cycles.
  task automatic push_cmd(input logic [1:0] m, input logic [3:0] d, input logic [2:0] c,
                          output int waited);
    int n;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_data  = d;
    cmd_count = c;
    while (cmd_ready !== 1'b1 && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL push_timeout ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock);
    n = (c == 3'd0) ? 8 : int'(c);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{mode: m, data: d, done: (i == n - 1)});
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // Wait for all expectations to be consumed, then require a fully idle sequencer.
  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || MODE !== 2'b00 || DATAIN !== 4'b0000 || cmd_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle busy=%b MODE=%b DATAIN=%b done=%b required 0/00/0000/0",
               name, busy, MODE, DATAIN, cmd_done);
    end
    @(negedge clock);
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({MODE, DATAIN, cmd_done, busy, cmd_ready} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs MODE=%b DATAIN=%b done=%b busy=%b ready=%b required all 0",
               MODE, DATAIN, cmd_done, busy, cmd_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
    @(negedge clock);
  endtask

  task automatic test_single;
    int w;
    push_cmd(2'b11, 4'b1010, 3'd3, w);
    checks++;
    if (MODE !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency MODE=%b busy=%b required 00/1", MODE, busy);
    end
    @(posedge clock);
    #1;
    checks++;
    if (MODE !== 2'b11 || DATAIN !== 4'b1010 || cmd_done !== 1'b0) begin
      errors++;
      $display("FAIL single_first MODE=%b DATAIN=%b done=%b required 11/1010/0", MODE, DATAIN, cmd_done);
    end
    @(negedge clock);
    wait_drain("single");
  endtask

  task automatic test_back_to_back;
    int w;
    push_cmd(2'b01, 4'b0011, 3'd2, w);
    push_cmd(2'b10, 4'b0111, 3'd1, w);
    wait_drain("b2b");
  endtask

  task automatic test_count_zero;
    int w;
    push_cmd(2'b01, 4'b0001, 3'd0, w);
    wait_drain("count0");
  endtask

  task automatic test_full;
    int w;
    push_cmd(2'b01, 4'b0001, 3'd7, w);
    push_cmd(2'b10, 4'b0010, 3'd1, w);
    push_cmd(2'b11, 4'b0011, 3'd1, w);
    push_cmd(2'b01, 4'b0100, 3'd2, w);
    push_cmd(2'b10, 4'b0101, 3'd1, w);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_ready ready=%b busy=%b required 0/1", cmd_ready, busy);
    end
    push_cmd(2'b11, 4'b0110, 3'd1, w);
    checks++;
    if (w != 4) begin
      errors++;
      $display("FAIL full_wait cycles=%0d required 4", w);
    end
    wait_drain("full");
  endtask

  task automatic test_simul_push_pop;
    int w;
    push_cmd(2'b11, 4'b1001, 3'd3, w);
    push_cmd(2'b01, 4'b1010, 3'd2, w);
    push_cmd(2'b10, 4'b1011, 3'd1, w);
    @(negedge clock);
    push_cmd(2'b11, 4'b1101, 3'd2, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL simul_accept wait=%0d required 0", w);
    end
    push_cmd(2'b01, 4'b1110, 3'd1, w);
    wait_drain("simul");
  endtask

  task automatic test_reset_mid;
    int w;
    push_cmd(2'b01, 4'b0101, 3'd7, w);
    push_cmd(2'b10, 4'b0110, 3'd2, w);
    push_cmd(2'b11, 4'b1100, 3'd5, w);
    @(negedge clock);
    #3;
    reset = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if ({MODE, DATAIN, cmd_done, busy, cmd_ready} !== 9'b0) begin
      errors++;
      $display("FAIL midreset_outputs MODE=%b DATAIN=%b done=%b busy=%b ready=%b required all 0",
               MODE, DATAIN, cmd_done, busy, cmd_ready);
    end
    #19;
    checks++;
    if ({MODE, DATAIN, cmd_done, busy} !== 8'b0) begin
      errors++;
      $display("FAIL midreset_hold MODE=%b DATAIN=%b done=%b busy=%b required all 0",
               MODE, DATAIN, cmd_done, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready ready=%b required 1", cmd_ready);
    end
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || MODE !== 2'b00) begin
      errors++;
      $display("FAIL midreset_discard busy=%b MODE=%b required 0/00", busy, MODE);
    end
    @(negedge clock);
    push_cmd(2'b10, 4'b1111, 3'd2, w);
    wait_drain("postreset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_count_zero();
    test_full();
    test_simul_push_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_cmd_sequencer.md
SHIFT_CMD_SEQUENCER -- requirements
Module: shift_cmd_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, command-buffer entries (power of two, >= 2).
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_ready  output  1  sequencer can accept a command this cycle.
REQ-006 cmd_mode  input  2  requested shift-register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 cmd_data  input  4  data word presented to the shift register with the command.
REQ-008 cmd_count  input  3  cycles to apply the command; 1..7 literal, 0 means 8.
REQ-009 MODE  output  2  mode driven to the downstream universal shift register.
REQ-010 DATAIN  output  4  data driven to the downstream universal shift register.
REQ-011 busy  output  1  a command is being issued or the FIFO is non-empty.
REQ-012 cmd_done  output  1  one-cycle pulse on the last issue cycle of each command.

Function
REQ-013 Command accepted on a rising edge where cmd_valid && cmd_ready; {mode,data,count} written to the FIFO tail.
REQ-014 cmd_ready SHALL be 1 exactly when FIFO occupancy < FIFO_DEPTH; no push-through when full, even if a pop occurs the same edge.
REQ-015 Simultaneous push and pop with 0 < occupancy < FIFO_DEPTH SHALL leave occupancy unchanged and preserve order.
REQ-016 FSM states IDLE and ISSUE only.
REQ-017 IDLE: MODE=00, DATAIN=0000, cmd_done=0; if FIFO non-empty, pop head on the next edge, load MODE/DATAIN from it, load remaining-count register, go to ISSUE.
REQ-018 Latency: a command accepted at edge E into an empty FIFO while IDLE SHALL appear on MODE/DATAIN after edge E+1.
REQ-019 ISSUE: MODE/DATAIN held constant for exactly the command's count cycles (8 when count=0); remaining count decrements each edge.
REQ-020 cmd_done SHALL be 1 during the final cycle of a command's ISSUE window only.
REQ-021 At end of window, if FIFO non-empty, next command loaded on the same edge (back-to-back, no hold gap); else return to IDLE with MODE=00, DATAIN=0000.
REQ-022 MODE, DATAIN, cmd_done SHALL be registered outputs; cmd_ready and busy may be combinational from registered state only.
REQ-023 busy = (state==ISSUE) || FIFO non-empty.

Reset
REQ-024 While reset high: MODE=00, DATAIN=0000, cmd_done=0, busy=0, cmd_ready=0, FIFO empty, state IDLE, counter 0.
REQ-025 Reset asserted mid-ISSUE SHALL abort the command and discard all buffered commands; no cmd_done for aborted commands.
REQ-026 First edge after reset deassertion: cmd_ready=1, commands accepted normally.

Structure
REQ-027 Package shift_cmd_pkg holds mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD), the FSM state type, and the 9-bit command record type {mode, data, count}.
REQ-028 One sub-module, shift_cmd_fifo: synchronous FIFO, parameterised depth and width, full/empty/occupancy outputs, async active-high reset.

Verification
REQ-029 Reset: assert reset 20 ns mid-operation -> MODE=00, DATAIN=0000, busy=0, cmd_done=0 immediately; cmd_ready=1 after first post-reset edge.
REQ-030 Single command {11,1010,3} into idle -> MODE=11/DATAIN=1010 for exactly 3 cycles from edge E+1, cmd_done on third, then MODE=00, busy=0.
REQ-031 Back-to-back {01,0011,2} then {10,0111,1} -> MODE 01,01,10 with no 00 gap; cmd_done on cycles 2 and 3.
REQ-032 Count 0: {01,0001,0} -> MODE=01 held 8 cycles, single cmd_done on 8th.
REQ-033 Full: push 5 commands with cmd_valid held while first issues (count 7) -> cmd_ready=0 once 4 buffered; 5th accepted only after a pop edge; issue order matches push order.
REQ-034 Simultaneous push/pop at occupancy 2 -> occupancy stays 2, no command lost or duplicated (checked by scoreboard of MODE/DATAIN sequence).
